// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types, defaults and pattern masking for seq_detector_param
package seq_det_pkg;

  typedef enum logic {
    S_FILL,
    S_ARMED
  } seq_det_state_t;

  localparam logic [15:0] DEF_PATTERN = 16'h006D;
  localparam int          DEF_LEN     = 7;
  localparam int          MASK_W      = 32;

  // Zeroes every pattern bit at or above len; callers zero-extend to MASK_W.
  function automatic logic [MASK_W-1:0] mask_pattern(input logic [MASK_W-1:0] pattern,
                                                      input int unsigned       len);
    logic [MASK_W-1:0] masked;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      masked[i] = pattern[i] & (i < len);
    end
    return masked;
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// rtl/seq_detector_param_if.sv - serial input, configuration and match status bundle
interface seq_detector_param_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
);

  logic               in;
  logic               in_valid;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               out;
  logic [CNT_W-1:0]   match_count;
  logic               armed;

  modport master (
    output in, in_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap,
    input  out, match_count, armed
  );

  modport slave (
    input  in, in_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap,
    output out, match_count, armed
  );

endinterface

// File: rtl/seq_det_hist.sv
// rtl/seq_det_hist.sv - bit history, fill counter and masked compare against the pattern
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               clear,
  input  logic               shift,
  input  logic               din,
  input  logic               ovl,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  output logic               reach,
  output logic               match
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_inc;

  assign hist_next = {hist[MAX_LEN-2:0], din};
  assign fill_inc  = (fill == FILL_MAX) ? fill : fill + 1'b1;
  assign reach     = (len != '0) && (fill_inc >= len);
  assign match     = reach &&
                     (mask_pattern(MASK_W'(hist_next), 32'(len)) ==
                      mask_pattern(MASK_W'(pat), 32'(len)));

  always_ff @(posedge clk) begin
    if (clr || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_next;
      // Non-overlap mode restarts the fill so no matched bit is reused.
      fill <= (match && !ovl) ? '0 : fill_inc;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - programmable serial pattern detector; SEQDET_COUNT_EN enables the match counter
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 16,
  parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_PATTERN),
  parameter int                 RST_LEN     = DEF_LEN,
  parameter bit                 RST_OVERLAP = 1'b1
) (
  input logic                  Clk,
  input logic                  Clr,
  seq_detector_param_if.slave  bus
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_RST = (RST_LEN > MAX_LEN) ? LEN_MAX : LEN_W'(RST_LEN);

  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;
  seq_det_state_t     state;
  logic               accept;
  logic               reach;
  logic               match;
  logic               hit;

  // A configuration write discards any bit presented on the same cycle.
  assign accept = bus.in_valid & ~bus.cfg_we;
  assign hit    = accept & match;

  seq_det_hist #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk   (Clk),
    .clr   (Clr),
    .clear (bus.cfg_we),
    .shift (accept),
    .din   (bus.in),
    .ovl   (ovl),
    .pat   (pat),
    .len   (len),
    .reach (reach),
    .match (match)
  );

  always_ff @(posedge Clk) begin
    if (Clr) begin
      pat     <= RST_PATTERN;
      len     <= LEN_RST;
      ovl     <= RST_OVERLAP;
      state   <= S_FILL;
      bus.out <= 1'b0;
    end else begin
      bus.out <= hit;
      if (bus.cfg_we) begin
        pat   <= bus.cfg_pattern;
        len   <= (bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;
        ovl   <= bus.cfg_overlap;
        state <= S_FILL;
      end else if (accept) begin
        case (state)
          S_FILL:  if (reach && !(match && !ovl)) state <= S_ARMED;
          S_ARMED: if (match && !ovl)             state <= S_FILL;
          default:                                state <= S_FILL;
        endcase
      end
    end
  end

  assign bus.armed = (state == S_ARMED);

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      cnt <= '0;
    end else if (hit && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.match_count = cnt;
`else
  assign bus.match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed self-checking bench for seq_detector_param
module tb_seq_detector_param;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int CNT_W   = 2;

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_detector_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .Clk (clk),
    .Clr (clr),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef SEQDET_COUNT_EN
    return (n > 3) ? 32'd3 : 32'(n);
`else
    return (n > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic tick(input logic v, input logic b, input logic we);
    bus.in       = b;
    bus.in_valid = v;
    bus.cfg_we   = we;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    clr = 1'b0;
  endtask

  task automatic load_cfg(input logic [15:0] p, input logic [4:0] l, input logic o);
    bus.cfg_pattern = p;
    bus.cfg_len     = l;
    bus.cfg_overlap = o;
    tick(1'b0, 1'b0, 1'b1);
  endtask

  // Streams n bits oldest-first; got[c] holds out after cycle c (idle cycles when gap is set).
  task automatic stream(input logic [31:0] bits, input int n, input bit gap, output logic [31:0] got);
    int c = 0;
    got = '0;
    for (int i = 0; i < n; i++) begin
      tick(1'b1, bits[n-1-i], 1'b0);
      got[c] = bus.out;
      c++;
      if (gap) begin
        tick(1'b0, 1'b0, 1'b0);
        got[c] = bus.out;
        c++;
      end
    end
  endtask

  initial begin
    logic [31:0] got;
    clr             = 1'b0;
    bus.in          = 1'b0;
    bus.in_valid    = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_overlap = 1'b0;

    do_reset();
    check_eq("rst_out", 32'(bus.out), 32'd0);
    check_eq("rst_armed", 32'(bus.armed), 32'd0);
    check_eq("rst_count", 32'(bus.match_count), 32'd0);

    // Default 1101101, single occurrence.
    stream(32'b1101101, 7, 1'b0, got);
    check_eq("def_pulses", got, 32'h0000_0040);
    check_eq("def_armed", 32'(bus.armed), 32'd1);
    check_eq("def_count", 32'(bus.match_count), cnt_exp(1));

    // Overlapping then non-overlapping on 1101101101.
    do_reset();
    stream(32'b1101101101, 10, 1'b0, got);
    check_eq("ovl_pulses", got, 32'h0000_0240);
    check_eq("ovl_count", 32'(bus.match_count), cnt_exp(2));
    load_cfg(16'h006D, 5'd7, 1'b0);
    stream(32'b1101101101, 10, 1'b0, got);
    check_eq("novl_pulses", got, 32'h0000_0040);
    check_eq("novl_armed", 32'(bus.armed), 32'd0);
    check_eq("novl_count", 32'(bus.match_count), cnt_exp(3));

    // 16-bit pattern with idle cycles between valid bits.
    do_reset();
    load_cfg(16'hA5A5, 5'd16, 1'b1);
    stream(32'h0000_A5A5, 16, 1'b1, got);
    check_eq("gap_pulses", got, 32'h4000_0000);
    check_eq("gap_armed", 32'(bus.armed), 32'd1);

    // cfg_we on the final matching bit wins; history restarts.
    do_reset();
    stream(32'b110110, 6, 1'b0, got);
    bus.cfg_pattern = 16'h006D;
    bus.cfg_len     = 5'd7;
    bus.cfg_overlap = 1'b1;
    tick(1'b1, 1'b1, 1'b1);
    check_eq("cfgwe_out", 32'(bus.out), 32'd0);
    check_eq("cfgwe_armed", 32'(bus.armed), 32'd0);
    stream(32'b110110, 6, 1'b0, got);
    check_eq("cfgwe_refill", got, 32'd0);
    check_eq("cfgwe_refill_armed", 32'(bus.armed), 32'd0);
    stream(32'b1, 1, 1'b0, got);
    check_eq("cfgwe_final", got, 32'd1);
    check_eq("cfgwe_count", 32'(bus.match_count), cnt_exp(1));

    // Clr after 5 of 7 bits discards the partial pattern.
    do_reset();
    stream(32'b11011, 5, 1'b0, got);
    clr = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    clr = 1'b0;
    check_eq("clr_edge_out", 32'(bus.out), 32'd0);
    stream(32'b1, 1, 1'b0, got);
    check_eq("clr_tail", got, 32'd0);
    check_eq("clr_armed", 32'(bus.armed), 32'd0);
    check_eq("clr_count", 32'(bus.match_count), 32'd0);

    // Pattern 11 (upper bits ignored): back-to-back pulses and counter saturation.
    do_reset();
    load_cfg(16'hFFF3, 5'd2, 1'b1);
    stream(32'b111111, 6, 1'b0, got);
    check_eq("b2b_pulses", got, 32'b111110);
    check_eq("sat_count", 32'(bus.match_count), cnt_exp(5));

    // Length above MAX_LEN clamps; length 0 disables.
    do_reset();
    load_cfg(16'hFFFF, 5'd20, 1'b1);
    stream(32'h0000_FFFF, 16, 1'b0, got);
    check_eq("clamp_pulses", got, 32'h0000_8000);
    load_cfg(16'hFFFF, 5'd0, 1'b1);
    stream(32'h000F_FFFF, 20, 1'b0, got);
    check_eq("len0_pulses", got, 32'd0);
    check_eq("len0_armed", 32'(bus.armed), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Runtime-programmable serial bit-pattern detector, the parametrised successor of the team's fixed 7-bit sequence detector. It samples one qualified serial bit per cycle and compares the most recent `len` bits against a loaded pattern of up to `MAX_LEN` bits. It emits a registered one-cycle match pulse and supports overlapping or non-overlapping detection. It sits on the serial input path beside the existing pattern-recognition logic and reuses its clock and clear nets.

## Interface
- `MAX_LEN`, 16: maximum pattern length in bits, ≥2.
- `LEN_W`, $clog2(MAX_LEN+1): width of length fields.
- `CNT_W`, 8: match counter width.
- `RST_PATTERN`, 16'h006D: pattern loaded at reset. Right-aligned, oldest bit first, so the default is 1101101.
- `RST_LEN`, 7: length loaded at reset.
- `RST_OVERLAP`, 1: overlap mode loaded at reset.
- `Clk` in 1: sole clock, rising edge.
- `Clr` in 1: reset, synchronous, active-high.
- `in` in 1: serial data bit.
- `in_valid` in 1: `in` is sampled only when high.
- `cfg_we` in 1: load the configuration below.
- `cfg_pattern` in MAX_LEN: new pattern. Bit `cfg_len-1` is the oldest bit; bit 0 is the newest.
- `cfg_len` in LEN_W: new length.
- `cfg_overlap` in 1: 1 = overlapping matches, 0 = non-overlapping.
- `out` out 1: match pulse, registered.
- `match_count` out CNT_W: saturating count of matches.
- `armed` out 1: history holds at least `len` valid bits.

## Operation
- Internal state:
  - `pat`, `len`, `ovl` configuration registers.
  - `hist[MAX_LEN-1:0]` shift register.
  - `fill` counter, 0..MAX_LEN, saturating.
- Accepted bit (`in_valid`=1, `cfg_we`=0):
  - `hist <= {hist[MAX_LEN-2:0], in}`.
  - `fill` increments and saturates at MAX_LEN.
- Match condition, evaluated on the post-shift history: `len`≠0, `fill_next` ≥ `len`, and `hist_next[len-1:0] == pat[len-1:0]`.
- On a match:
  - `out` <= 1 on that edge; otherwise `out` <= 0.
  - If `ovl`=0, `fill` <= 0 instead of incrementing, so no bit of the matched window is reused.
  - If `ovl`=1, `fill` behaves normally, so every overlapping occurrence is reported.
- Idle cycle (`in_valid`=0): `hist` and `fill` hold; `out` <= 0.
- Length rules:
  - `cfg_len`=0 disables detection; `out` stays 0 and `armed` stays 0.
  - `cfg_len` > MAX_LEN is clamped to MAX_LEN.
  - Pattern bits at or above `len` are ignored.
- FSM, two states (`fill` kept alongside):
  - FILL: `fill` < `len`; `armed`=0.
  - ARMED: `fill` ≥ `len`; `armed`=1.
  - FILL→ARMED when an accepted bit brings `fill` up to `len`.
  - ARMED→FILL on a non-overlap match, on `cfg_we`, or on `Clr`.
- Simultaneous events:
  - `cfg_we` together with `in_valid`: the configuration wins and the bit is discarded. `hist` and `fill` clear, `out` <= 0, and `match_count` is unchanged.
  - `Clr` overrides everything.
- Reset values:
  - `out`=0, `armed`=0, `match_count`=0.
  - `hist`=0, `fill`=0, state FILL.
  - `pat`=RST_PATTERN, `len`=RST_LEN (clamped), `ovl`=RST_OVERLAP.
- Reset mid-stream: a partially received pattern is discarded, and no pulse is produced for bits sampled on the `Clr` edge.

## Timing
- Latency: `out` is high for exactly the one cycle after the edge that samples the final pattern bit.
- Back-to-back overlapping matches give consecutive `out` pulses, e.g. pattern 11 on input 111.
- The new configuration applies starting with the first accepted bit after the `cfg_we` edge.
- `armed` and `match_count` are registered and update on the same edge as `out`.

## Configuration
- `SEQDET_COUNT_EN` defined:
  - `match_count` increments on every `out` pulse and saturates at 2^CNT_W−1.
  - `match_count` clears only on `Clr`.
- Not defined: `match_count` is tied to 0 and no counter flops exist. Port list is identical in both builds.

## Structure
- Package `seq_det_pkg` holds:
  - state enum `seq_det_state_t` {S_FILL, S_ARMED};
  - localparams for the default pattern and length;
  - a function that masks a pattern to `len` bits.
- One sub-module, `seq_det_hist`: the shift register, the `fill` counter and the masked compare. The top level holds the configuration registers, FSM, `out` register and counter.

## Test plan
- Reset defaults, input 1101101 → `out` pulses once, one cycle after the 7th bit; `match_count`=1.
- Default config, input 1101101101 with overlap=1 → two pulses (after bits 7 and 10). After reloading with overlap=0, the same stream → one pulse.
- Load pattern 0xA5A5, len 16, stream it with `in_valid` toggling every other cycle → exactly one pulse, after the 16th valid bit; idle cycles hold the state.
- `cfg_we` asserted on the cycle carrying the final matching bit → no pulse, `armed`=0, `fill` restarts from 0.
- `Clr` asserted after 5 of 7 bits, then the remaining 2 bits → no pulse, and all outputs stay at reset values.
- With `SEQDET_COUNT_EN` and CNT_W=2, 5 matches → `match_count`=3 (saturated). Without the macro, `match_count`=0 throughout.
